// File: rtl/zpura_timer_pkg.sv
// Shared definitions for the zpura multi-channel countdown timer.
// Contents:
//   - register offsets (address[3:2]) within a 16-byte channel window
//   - CTRL bit positions
//   - ctrl_t packed control struct and a helper that extracts it from a bus word
package zpura_timer_pkg;

  localparam logic [1:0] REG_COUNT  = 2'd0;
  localparam logic [1:0] REG_RELOAD = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  localparam int CTRL_ENABLE_BIT      = 0;
  localparam int CTRL_AUTO_RELOAD_BIT = 1;
  localparam int CTRL_IRQ_EN_BIT      = 2;

  typedef struct packed {
    logic irq_en;
    logic auto_reload;
    logic enable;
  } ctrl_t;

  // Pull the three CTRL fields out of a 32-bit write word; other bits are dropped.
  function automatic ctrl_t ctrl_from_word(input logic [31:0] w);
    ctrl_t c;
    c.enable      = w[CTRL_ENABLE_BIT];
    c.auto_reload = w[CTRL_AUTO_RELOAD_BIT];
    c.irq_en      = w[CTRL_IRQ_EN_BIT];
    return c;
  endfunction

endpackage

// File: rtl/timer_channel.sv
// One countdown channel: COUNT, RELOAD, CTRL and the sticky expired flag.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   tick                shared one-cycle prescaler tick
//   we_count/we_reload/we_ctrl/we_status   per-register write strobes
//   wdata[31:0]         write data from the bus
//   count, reload       register values (CNT_W bits)
//   ctrl                control fields
//   expired             sticky expiry flag
//   irq                 registered expired & irq_en
module timer_channel
  import zpura_timer_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             we_count,
  input  logic             we_reload,
  input  logic             we_ctrl,
  input  logic             we_status,
  input  logic [31:0]      wdata,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] reload,
  output ctrl_t            ctrl,
  output logic             expired,
  output logic             irq
);

  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] count_next_s;
  logic [CNT_W-1:0] reload_r;
  ctrl_t            ctrl_r;
  logic             expired_r;
  logic             expired_next_s;
  logic             expire_evt_s;
  logic             irq_r;

  // Next COUNT value and expiry event; a bus write to COUNT overrides the tick
  // entirely, so a write landing on a tick never produces an expiry.
  always_comb begin
    count_next_s = count_r;
    expire_evt_s = 1'b0;
    if (we_count) begin
      count_next_s = wdata[CNT_W-1:0];
    end else if (tick && ctrl_r.enable) begin
      if (count_r > CNT_ONE) begin
        count_next_s = count_r - CNT_ONE;
      end else if (count_r == CNT_ONE) begin
        expire_evt_s = 1'b1;
        count_next_s = ctrl_r.auto_reload ? reload_r : CNT_ZERO;
      end else begin
        // COUNT==0 is parked: no change and no repeated expiry
        count_next_s = count_r;
      end
    end else begin
      count_next_s = count_r;
    end
  end

  // Sticky flag update: a same-cycle expiry beats the W1C clear.
  always_comb begin
    expired_next_s = expired_r;
    if (expire_evt_s) begin
      expired_next_s = 1'b1;
    end else if (we_status && wdata[0]) begin
      expired_next_s = 1'b0;
    end else begin
      expired_next_s = expired_r;
    end
  end

  // Channel state registers; irq follows the flag one cycle later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r   <= CNT_ZERO;
      reload_r  <= CNT_ZERO;
      ctrl_r    <= ctrl_t'(3'b000);
      expired_r <= 1'b0;
      irq_r     <= 1'b0;
    end else begin
      count_r   <= count_next_s;
      if (we_reload) begin
        reload_r <= wdata[CNT_W-1:0];
      end
      if (we_ctrl) begin
        ctrl_r <= ctrl_from_word(wdata);
      end
      expired_r <= expired_next_s;
      irq_r     <= expired_r & ctrl_r.irq_en;
    end
  end

  assign count   = count_r;
  assign reload  = reload_r;
  assign ctrl    = ctrl_r;
  assign expired = expired_r;
  assign irq     = irq_r;

endmodule

// File: rtl/multi_countdown_timer.sv
// Memory-mapped bank of NUM_CH countdown timers sharing one prescaled tick.
// Each channel occupies 16 bytes starting at BASE_ADR: COUNT, RELOAD, CTRL, STATUS(W1C).
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   wren, rd            write / read strobes
//   address[31:0]       byte address (bits [1:0] ignored)
//   data_in[31:0]       write data
//   data_out[31:0]      combinational read data, 0 when not reading or out of range
//   irq                 OR of irq_vec
//   irq_vec[NUM_CH-1:0] per-channel expired & irq_en (registered)
module multi_countdown_timer
  import zpura_timer_pkg::*;
#(
  parameter logic [31:0] BASE_ADR  = 32'h8008_0100,
  parameter int          NUM_CH    = 4,
  parameter int          CNT_W     = 32,
  parameter int          CLK_FQ_HZ = 50000000,
  parameter int          TICK_HZ   = 1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wren,
  input  logic              rd,
  input  logic [31:0]       address,
  input  logic [31:0]       data_in,
  output logic [31:0]       data_out,
  output logic              irq,
  output logic [NUM_CH-1:0] irq_vec
);

  localparam int               DIV       = CLK_FQ_HZ / TICK_HZ;
  localparam int               PRE_W     = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(DIV - 1);
  localparam logic [PRE_W-1:0] PRE_ZERO  = PRE_W'(0);
  localparam logic [PRE_W-1:0] PRE_ONE   = PRE_W'(1);
  localparam logic [31:0]      WIN_BYTES = 32'(NUM_CH * 16);

  logic [PRE_W-1:0] presc_r;
  logic             tick_s;

  logic [31:0] offset_s;
  logic        hit_s;
  logic [3:0]  ch_sel_s;
  logic [1:0]  reg_sel_s;

  logic [NUM_CH-1:0][CNT_W-1:0] count_s;
  logic [NUM_CH-1:0][CNT_W-1:0] reload_s;
  ctrl_t [NUM_CH-1:0]           ctrl_s;
  logic [NUM_CH-1:0]            expired_s;
  logic [NUM_CH-1:0]            irq_s;
  logic [NUM_CH-1:0]            ch_hit_s;
  logic [NUM_CH-1:0][31:0]      rd_word_s;
  logic [31:0]                  rd_mux_s;

  // Free-running prescaler 0..DIV-1; bus writes never disturb it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_r <= PRE_ZERO;
    end else if (tick_s) begin
      presc_r <= PRE_ZERO;
    end else begin
      presc_r <= presc_r + PRE_ONE;
    end
  end

  assign tick_s = (presc_r == PRE_LAST);

  // Unsigned subtraction wraps addresses below BASE_ADR to huge offsets,
  // so a single upper-bound compare covers both sides of the window.
  assign offset_s  = address - BASE_ADR;
  assign hit_s     = (offset_s < WIN_BYTES);
  assign ch_sel_s  = offset_s[7:4];
  assign reg_sel_s = address[3:2];

  for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
    logic [31:0] word_s;

    assign ch_hit_s[n] = hit_s && (ch_sel_s == 4'(n));

    timer_channel #(
      .CNT_W(CNT_W)
    ) u_channel (
      .clk       (clk),
      .rst       (rst),
      .tick      (tick_s),
      .we_count  (wren && ch_hit_s[n] && (reg_sel_s == REG_COUNT)),
      .we_reload (wren && ch_hit_s[n] && (reg_sel_s == REG_RELOAD)),
      .we_ctrl   (wren && ch_hit_s[n] && (reg_sel_s == REG_CTRL)),
      .we_status (wren && ch_hit_s[n] && (reg_sel_s == REG_STATUS)),
      .wdata     (data_in),
      .count     (count_s[n]),
      .reload    (reload_s[n]),
      .ctrl      (ctrl_s[n]),
      .expired   (expired_s[n]),
      .irq       (irq_s[n])
    );

    // Zero-extended read word of the register selected in this channel.
    always_comb begin
      case (reg_sel_s)
        REG_COUNT:  word_s = 32'(count_s[n]);
        REG_RELOAD: word_s = 32'(reload_s[n]);
        REG_CTRL:   word_s = 32'(ctrl_s[n]);
        REG_STATUS: word_s = {31'd0, expired_s[n]};
        default:    word_s = 32'd0;
      endcase
    end

    assign rd_word_s[n] = word_s;
  end

  // One-hot channel select folded into an OR tree; no hit yields 0.
  always_comb begin
    rd_mux_s = 32'd0;
    for (int n = 0; n < NUM_CH; n++) begin
      rd_mux_s = rd_mux_s | (ch_hit_s[n] ? rd_word_s[n] : 32'd0);
    end
  end

  assign data_out = (rd && !wren) ? rd_mux_s : 32'd0;
  assign irq_vec  = irq_s;
  assign irq      = |irq_s;

endmodule
